// File: rtl/cv32e40s_pma_splitter.sv
// PMA front-end: checks a core access against the region table, splits word-crossing
// accesses into two aligned bus transactions and keeps responses in order.
module cv32e40s_pma_splitter #(
    parameter int unsigned PMA_NUM_REGIONS = 0,
    // Region i occupies PMA_CFG[i*68 +: 68] = {word_addr_low, word_addr_high,
    // main, bufferable, cacheable, integrity}; all-zero entry is PMA_R_DEFAULT.
    parameter logic [((PMA_NUM_REGIONS == 0) ? 1 : PMA_NUM_REGIONS)*68-1:0] PMA_CFG = '0,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        core_req_i,
    output logic        core_gnt_o,
    input  logic [31:0] core_addr_i,
    input  logic [1:0]  core_size_i,
    input  logic        core_we_i,
    input  logic        core_instr_i,
    output logic        bus_req_o,
    input  logic        bus_gnt_i,
    output logic [31:0] bus_addr_o,
    output logic [3:0]  bus_be_o,
    output logic        bus_bufferable_o,
    output logic        bus_cacheable_o,
    output logic        bus_integrity_o,
    input  logic        bus_rvalid_i,
    output logic        core_rvalid_o,
    output logic        core_err_o
);

    localparam int unsigned CntW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CntW-1:0] MaxCnt = CntW'(MAX_OUTSTANDING);

    typedef enum logic [1:0] {StIdle, StSecond, StErr} state_e;

    state_e                     r_state, w_state_d;
    logic [CntW-1:0]            r_cnt, w_cnt_d;
    logic [MAX_OUTSTANDING-1:0] r_flags, w_flags_d;
    logic                       r_active;
    logic [31:0]                r_addr1;
    logic [3:0]                 r_be1;
    logic                       r_buf1, r_cache1, r_integ1;

    logic [3:0]  w_mask;
    logic [7:0]  w_shift;
    logic        w_split, w_error, w_room, w_pop;
    logic [31:0] w_addr0, w_addr1;
    logic [3:0]  w_attr0, w_attr1;
    logic        w_buf0, w_buf1;
    logic        w_push, w_push_flag, w_latch, w_err_rsp;
    logic [CntW-1:0] w_idx;

    // Returns {main, bufferable, cacheable, integrity}; lowest matching index wins.
    function automatic logic [3:0] f_lookup(input logic [29:0] wa);
        logic [31:0] wa32;
        logic [67:0] ent;
        logic        found;
        logic [3:0]  attr;
        wa32  = {2'b00, wa};
        found = 1'b0;
        attr  = (PMA_NUM_REGIONS == 0) ? 4'b1000 : 4'b0000;
        for (int i = 0; i < int'(PMA_NUM_REGIONS); i++) begin
            ent = PMA_CFG[i*68 +: 68];
            if (!found && wa32 >= ent[67:36] && wa32 < ent[35:4]) begin
                found = 1'b1;
                attr  = ent[3:0];
            end
        end
        return attr;
    endfunction

    always_comb begin
        unique case (core_size_i)
            2'd0:    w_mask = 4'b0001;
            2'd1:    w_mask = 4'b0011;
            default: w_mask = 4'b1111;
        endcase
    end

    assign w_shift = {4'b0000, w_mask} << core_addr_i[1:0];
    assign w_split = |w_shift[7:4];
    assign w_addr0 = {core_addr_i[31:2], 2'b00};
    assign w_addr1 = w_addr0 + 32'd4;
    assign w_attr0 = f_lookup(w_addr0[31:2]);
    assign w_attr1 = f_lookup(w_addr1[31:2]);
    assign w_buf0  = w_attr0[2] & core_we_i & ~core_instr_i;
    assign w_buf1  = w_attr1[2] & core_we_i & ~core_instr_i;
    assign w_error = (core_instr_i | w_split) & (~w_attr0[3] | (w_split & ~w_attr1[3]));
    assign w_room  = (r_cnt < MaxCnt);
    assign w_pop   = r_active & bus_rvalid_i & (r_cnt != '0);

    always_comb begin
        w_state_d        = r_state;
        bus_req_o        = 1'b0;
        bus_addr_o       = 32'h0;
        bus_be_o         = 4'h0;
        bus_bufferable_o = 1'b0;
        bus_cacheable_o  = 1'b0;
        bus_integrity_o  = 1'b0;
        core_gnt_o       = 1'b0;
        w_err_rsp        = 1'b0;
        w_push           = 1'b0;
        w_push_flag      = 1'b0;
        w_latch          = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (core_req_i) begin
                    if (w_error) begin
                        core_gnt_o = 1'b1;
                        w_state_d  = StErr;
                    end else if (w_room) begin
                        bus_req_o        = 1'b1;
                        bus_addr_o       = w_addr0;
                        bus_be_o         = w_shift[3:0];
                        bus_bufferable_o = w_buf0;
                        bus_cacheable_o  = w_attr0[1];
                        bus_integrity_o  = w_attr0[0];
                        if (bus_gnt_i) begin
                            w_push      = 1'b1;
                            w_push_flag = ~w_split;
                            if (w_split) begin
                                w_latch   = 1'b1;
                                w_state_d = StSecond;
                            end else begin
                                core_gnt_o = 1'b1;
                            end
                        end
                    end
                end
            end
            StSecond: begin
                if (w_room) begin
                    bus_req_o        = 1'b1;
                    bus_addr_o       = r_addr1;
                    bus_be_o         = r_be1;
                    bus_bufferable_o = r_buf1;
                    bus_cacheable_o  = r_cache1;
                    bus_integrity_o  = r_integ1;
                    if (bus_gnt_i) begin
                        w_push      = 1'b1;
                        w_push_flag = 1'b1;
                        core_gnt_o  = 1'b1;
                        w_state_d   = StIdle;
                    end
                end
            end
            StErr: begin
                // Error response waits until every earlier bus response has drained.
                if (r_cnt == '0 && !bus_rvalid_i) begin
                    w_err_rsp = 1'b1;
                    w_state_d = StIdle;
                end
            end
            default: w_state_d = StIdle;
        endcase
        if (!r_active) begin
            w_state_d        = StIdle;
            bus_req_o        = 1'b0;
            bus_addr_o       = 32'h0;
            bus_be_o         = 4'h0;
            bus_bufferable_o = 1'b0;
            bus_cacheable_o  = 1'b0;
            bus_integrity_o  = 1'b0;
            core_gnt_o       = 1'b0;
            w_err_rsp        = 1'b0;
            w_push           = 1'b0;
            w_latch          = 1'b0;
        end
    end

    assign core_rvalid_o = (w_pop & r_flags[0]) | w_err_rsp;
    assign core_err_o    = w_err_rsp;

    // Occupancy equals r_cnt, so the FIFO is a shift register popped from bit 0.
    assign w_idx   = r_cnt - CntW'(w_pop);
    assign w_cnt_d = r_cnt + CntW'(w_push) - CntW'(w_pop);

    always_comb begin
        w_flags_d = w_pop ? (r_flags >> 1) : r_flags;
        for (int i = 0; i < int'(MAX_OUTSTANDING); i++) begin
            if (w_push && CntW'(i) == w_idx) begin
                w_flags_d[i] = w_push_flag;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= StIdle;
            r_cnt    <= '0;
            r_flags  <= '0;
            r_active <= 1'b0;
            r_addr1  <= 32'h0;
            r_be1    <= 4'h0;
            r_buf1   <= 1'b0;
            r_cache1 <= 1'b0;
            r_integ1 <= 1'b0;
        end else begin
            r_state  <= w_state_d;
            r_cnt    <= w_cnt_d;
            r_flags  <= w_flags_d;
            r_active <= 1'b1;
            if (w_latch) begin
                r_addr1  <= w_addr1;
                r_be1    <= w_shift[7:4];
                r_buf1   <= w_buf1;
                r_cache1 <= w_attr1[1];
                r_integ1 <= w_attr1[0];
            end
        end
    end

endmodule

// File: doc/cv32e40s_pma_splitter.md
# cv32e40s_pma_splitter

Sequential PMA front-end between the LSU/prefetcher request port and the OBI bus. Accepts one core transaction at a time and splits word-boundary-crossing accesses into two word-aligned bus transactions. PMA-checks both halves before anything is issued and blocks faulting transactions without touching the bus. Tracks outstanding bus transactions so blocked-access error responses and split-access responses return to the core in order; read-data merging is handled outside this block.

## Interface
- PMA_NUM_REGIONS, 0, number of PMA regions; 0 = PMA deconfigured, every address uses NO_PMA_R_DEFAULT.
- PMA_CFG, '{default:PMA_R_DEFAULT}, region array of pma_cfg_t (word_addr_low/high, main, bufferable, cacheable, integrity).
- MAX_OUTSTANDING, 2, maximum bus transactions in flight (range 1..8).
- clk  in  1  clock.
- rst_n  in  1  reset; one clock, reset asynchronous active-low.
- core_req_i  in  1  core request valid.
- core_gnt_o  out  1  core request accepted.
- core_addr_i  in  32  byte address.
- core_size_i  in  2  0=byte, 1=half, 2=word, 3 treated as word.
- core_we_i  in  1  store.
- core_instr_i  in  1  instruction fetch.
- bus_req_o  out  1  bus request.
- bus_gnt_i  in  1  bus grant.
- bus_addr_o  out  32  word-aligned address ([1:0]=0).
- bus_be_o  out  4  byte enables.
- bus_bufferable_o, bus_cacheable_o, bus_integrity_o  out  1 each  attributes of the issued half.
- bus_rvalid_i  in  1  bus response.
- core_rvalid_o  out  1  core response (one per accepted core transaction).
- core_err_o  out  1  response is a PMA error; valid with core_rvalid_o.

## Operation
- Region lookup (per half): word address = {2'b00, addr[31:2]}; match if word_addr_low <= wa < word_addr_high; lowest-index match wins; no match -> PMA_R_DEFAULT.
- Byte mask m = 0001/0011/1111 by size; 8-bit shifted mask s = m << addr[1:0]. Half0 be = s[3:0] at addr&~3; split iff s[7:4] != 0, half1 be = s[7:4] at (addr&~3)+4 (32-bit wrap: 0xFFFFFFFC+4 -> 0x0).
- Error iff any issued half has main=0 and (core_instr_i or split).
- Attributes per half: bufferable = cfg.bufferable & core_we_i & !core_instr_i; cacheable, integrity straight from cfg.
- FSM:
  - IDLE, core_req_i & error: core_gnt_o=1, no bus_req_o, go ERR.
  - IDLE, core_req_i & no error & count<MAX_OUTSTANDING: bus_req_o=1 with half0. On bus_gnt_i: if split go SECOND (core_gnt_o=0), else core_gnt_o=1 and stay IDLE.
  - SECOND: bus_req_o=1 with half1 (attributes/be latched at half0 grant, core inputs ignored). Issue is gated by count<MAX_OUTSTANDING. On bus_gnt_i: core_gnt_o=1, go IDLE.
  - ERR: accept nothing. When count==0 and no bus_rvalid_i this cycle, pulse core_rvalid_o=1, core_err_o=1 for one cycle, go IDLE.
- Outstanding counter: +1 per bus grant, -1 per bus_rvalid_i; both in one cycle = unchanged. bus_rvalid_i at count 0 is ignored and the counter stays 0.
- Last-flag FIFO (depth MAX_OUTSTANDING): push on every grant (1 = final half); pop on bus_rvalid_i. core_rvalid_o = bus_rvalid_i & popped flag; core_err_o=0 for bus responses. The first-half response of a split is suppressed.
- Core inputs must be held stable while core_req_i=1 and core_gnt_o=0.

## Timing
- Zero-cycle request path: bus_req_o/bus_addr_o/attributes combinational from core inputs in IDLE. core_gnt_o same cycle as the final bus_gnt_i.
- Split access occupies at least 2 cycles. Error grant is same-cycle; error response arrives at least 1 cycle later, after all earlier responses.
- Response path combinational: core_rvalid_o same cycle as bus_rvalid_i.
- Reset values: state IDLE, count 0, FIFO empty, latched half1 cleared. All outputs 0 while rst_n=0. Reset mid-split or mid-ERR abandons the transaction, with no response.

## Test plan
- Aligned word load 0x1000, main region, grant same cycle -> bus_addr_o=0x1000, be=1111, core_gnt_o same cycle, one core_rvalid_o, bufferable=0.
- Half store 0x2003 in main bufferable region -> bus 0x2000 be=1000, then 0x2004 be=0001, both bufferable=1. core_gnt_o on second grant; only the second bus_rvalid_i raises core_rvalid_o.
- Misaligned word 0x3002 with half1 in a non-main region -> no bus_req_o, core_gnt_o=1. With 2 responses outstanding, core_rvalid_o+core_err_o fires 1 cycle after the last bus_rvalid_i.
- Instruction fetch 0x4000 from non-main region -> error response, zero bus transactions. Same fetch with PMA_NUM_REGIONS=0 -> issued normally.
- MAX_OUTSTANDING=1: back-to-back aligned loads -> second bus_req_o held low until bus_rvalid_i. Simultaneous grant+rvalid keeps count=1.
- Assert rst_n low in SECOND -> all outputs 0 immediately; after release, a new request at 0xFFFFFFFE half -> halves at 0xFFFFFFFC be=1100 and 0x0 be=0000? no: size=half, s=1100 -> single transaction, not split.
